// File: rtl/vga_pkg.sv
// vga_pkg: default VGA timing, stream FSM states and the colour-bar table shared by vga_stream_out and vga_timing
package vga_pkg;
  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF = 16;
  localparam int H_SYNC_DEF = 96;
  localparam int H_BP_DEF = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF = 10;
  localparam int V_SYNC_DEF = 2;
  localparam int V_BP_DEF = 33;
  typedef enum logic {WAIT_SOF, RUN} state_e;
  // {R,G,B} on/off per bar, bar 0 in the low bits: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [23:0] BAR_RGB = 24'b000_001_100_101_010_011_110_111;
  function automatic logic [2:0] bar_rgb(input logic [2:0] i);
    return BAR_RGB[5'(i) * 5'd3 +: 3];
  endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: free-running h/v raster counters with active and sync-region decode
// ports: clk, rst (async, active high) in; h_cnt, v_cnt, active, hs_on, vs_on out (decode of current counts)
module vga_timing import vga_pkg::*; #(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          active,
  output logic          hs_on,
  output logic          vs_on
);
  // one spare bit so region bounds equal to TOTAL still compare correctly
  localparam logic [HW:0] H_ACT = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0] HS_BEG = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0] HS_END = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [VW:0] V_ACT = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0] VS_BEG = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0] VS_END = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  always_comb begin
    h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
    v_d = (h_q != H_LAST) ? v_q : (v_q == V_LAST) ? '0 : v_q + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end
  assign h_cnt = h_q;
  assign v_cnt = v_q;
  assign active = {1'b0, h_q} < H_ACT && {1'b0, v_q} < V_ACT;
  assign hs_on = {1'b0, h_q} >= HS_BEG && {1'b0, h_q} < HS_END;
  assign vs_on = {1'b0, v_q} >= VS_BEG && {1'b0, v_q} < VS_END;
endmodule

// File: rtl/vga_stream_out.sv
// vga_stream_out: pixel stream (valid/ready/tuser=SOF) to registered VGA colour and sync outputs
// ports: clk, rst (async, active high), s_tdata {R,G,B}, s_tvalid, s_tuser in; s_tready out;
//        VGA_R/G/B, vid_hsync, vid_vsync, vid_active, underflow, sof_err out (all registered, 1-cycle latency)
// option: VGA_TEST_PATTERN_EN adds input test_en selecting 8 vertical colour bars
module vga_stream_out import vga_pkg::*; #(
  parameter int COLOR_W = 4,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP = H_FP_DEF,
  parameter int H_SYNC = H_SYNC_DEF,
  parameter int H_BP = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP = V_FP_DEF,
  parameter int V_SYNC = V_SYNC_DEF,
  parameter int V_BP = V_BP_DEF,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                 test_en,
`endif
  input  logic [3*COLOR_W-1:0] s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic                 s_tuser,
  output logic [COLOR_W-1:0]   VGA_R,
  output logic [COLOR_W-1:0]   VGA_G,
  output logic [COLOR_W-1:0]   VGA_B,
  output logic                 vid_hsync,
  output logic                 vid_vsync,
  output logic                 vid_active,
  output logic                 underflow,
  output logic                 sof_err
);
  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic active, hs_on, vs_on, origin, ready;
  state_e state_q, state_d;
  logic [3*COLOR_W-1:0] rgb_q, rgb_d;
  logic active_q, hs_q, vs_q, uf_q, uf_d, se_q, se_d;
  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .active(active), .hs_on(hs_on), .vs_on(vs_on)
  );
  assign origin = h_cnt == '0 && v_cnt == '0;
`ifdef VGA_TEST_PATTERN_EN
  localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);
  logic [2:0] bar;
  assign bar = bar_rgb(3'(h_cnt / BAR_W));
`endif
  always_comb begin
    state_d = state_q;
    ready = 1'b0;
    uf_d = 1'b0;
    se_d = 1'b0;
    rgb_d = '0;
    if (state_q == WAIT_SOF) begin
      // non-SOF beats are drained at once; an SOF beat waits at the head until the raster origin
      ready = !s_tuser || origin;
      rgb_d = (s_tvalid && s_tuser && origin) ? s_tdata : '0;
      state_d = (s_tvalid && s_tuser && origin) ? RUN : WAIT_SOF;
    end else if (active) begin
      // a mid-frame SOF is left in place so it can start the next frame
      ready = !(s_tuser && !origin);
      uf_d = !s_tvalid;
      se_d = s_tvalid && s_tuser && !origin;
      rgb_d = (s_tvalid && ready) ? s_tdata : '0;
      state_d = (uf_d || se_d) ? WAIT_SOF : RUN;
    end
`ifdef VGA_TEST_PATTERN_EN
    // leaving test mode resynchronises on the next SOF
    if (test_en) begin
      ready = 1'b0;
      uf_d = 1'b0;
      se_d = 1'b0;
      state_d = WAIT_SOF;
      rgb_d = active ? {{COLOR_W{bar[2]}}, {COLOR_W{bar[1]}}, {COLOR_W{bar[0]}}} : '0;
    end
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_SOF;
      rgb_q <= '0;
      active_q <= 1'b0;
      hs_q <= !HS_POL;
      vs_q <= !VS_POL;
      uf_q <= 1'b0;
      se_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rgb_q <= rgb_d;
      active_q <= active;
      hs_q <= hs_on ? HS_POL : !HS_POL;
      vs_q <= vs_on ? VS_POL : !VS_POL;
      uf_q <= uf_d;
      se_q <= se_d;
    end
  end
  assign s_tready = ready && !rst;
  assign {VGA_R, VGA_G, VGA_B} = rgb_q;
  assign vid_active = active_q;
  assign vid_hsync = hs_q;
  assign vid_vsync = vs_q;
  assign underflow = uf_q;
  assign sof_err = se_q;
endmodule

// File: doc/vga_stream_out.md
VGA_STREAM_OUT -- requirements
Module: vga_stream_out

Interface
REQ-001 SHALL have parameter COLOR_W, default 4, bits per colour channel.
REQ-002 SHALL have parameters H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48, horizontal timing in pixel clocks.
REQ-003 SHALL have parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, vertical timing in lines.
REQ-004 SHALL have parameters HS_POL/VS_POL, default 0/0, asserted sync level.
REQ-005 SHALL have port clk  in  1  pixel clock; all logic on rising edge.
REQ-006 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port s_tdata  in  3*COLOR_W  pixel, packed {R,G,B}.
REQ-008 SHALL have ports s_tvalid in 1, s_tready out 1, s_tuser in 1 (start of frame), forming the pixel stream handshake.
REQ-009 SHALL have ports VGA_R/VGA_G/VGA_B  out  COLOR_W each  colour outputs.
REQ-010 SHALL have ports vid_hsync, vid_vsync, vid_active  out  1  sync and display-enable.
REQ-011 SHALL have ports underflow, sof_err  out  1  single-cycle error pulses.

Function
REQ-012 SHALL run h_cnt 0..H_TOTAL-1, wrapping to 0; v_cnt increments on h wrap, 0..V_TOTAL-1, wrapping to 0 (TOTAL = sum of the four terms).
REQ-013 SHALL define active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE; hsync region h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v_cnt.
REQ-014 SHALL register all outputs: one-cycle latency from counter state to vid_*/VGA_*; sync driven at HS_POL/VS_POL inside region, inverse outside.
REQ-015 SHALL implement FSM WAIT_SOF / RUN; a beat transfers when s_tvalid && s_tready.
REQ-016 SHALL, in WAIT_SOF, assert s_tready unless head beat has s_tuser=1, discarding non-SOF beats; when h_cnt=0, v_cnt=0 and head has s_tuser=1, assert s_tready, display it, enter RUN.
REQ-017 SHALL, in RUN, assert s_tready exactly on active cycles and display the accepted beat.
REQ-018 SHALL, in RUN on an active cycle with s_tvalid=0, output black, pulse underflow, go to WAIT_SOF.
REQ-019 SHALL, in RUN on an active cycle other than (0,0) with s_tvalid=1 and s_tuser=1, not consume, output black, pulse sof_err, go to WAIT_SOF.
REQ-020 SHALL drive VGA_* to zero whenever inactive or not displaying an accepted beat.
REQ-021 SHALL keep timing free-running regardless of FSM state or stream errors.

Reset
REQ-022 SHALL on rst: h_cnt=v_cnt=0, state=WAIT_SOF, VGA_*=0, vid_active=0, underflow=sof_err=0, syncs deasserted (!HS_POL, !VS_POL), s_tready=0 while rst high.
REQ-023 SHALL, on reset mid-frame, abandon the frame; the next transfer is the SOF discard/accept of REQ-016.

Configuration
REQ-024 SHALL, with VGA_TEST_PATTERN_EN defined, add input test_en (1 bit); when 1, display 8 vertical colour bars (width H_ACTIVE/8, full-scale per channel, order white, yellow, cyan, green, magenta, red, blue, black), hold s_tready=0, suppress error pulses.
REQ-025 SHALL, without VGA_TEST_PATTERN_EN, omit test_en and the pattern logic entirely.

Structure
REQ-026 SHALL place default timing constants, the FSM state enum and the colour-bar table in package vga_pkg.
REQ-027 SHALL implement counters and sync decode in sub-module vga_timing; the stream/FSM logic stays in the top.

Verification (H 8/2/2/2, V 4/1/1/1, COLOR_W=4, polarities 0)
REQ-028 SHALL check free-run after reset: hsync low for 2 clk every 14 clk, vsync low for 1 line every 7 lines, vid_active high 8 clk per line on lines 0-3.
REQ-029 SHALL check stream: 32 beats, first with tuser=1, data=index -> VGA_{R,G,B} show indices 0..31 in raster order from (0,0), no error pulses.
REQ-030 SHALL check SOF alignment: 5 non-SOF beats then SOF at h=5,v=2 -> 5 discarded, SOF held until (0,0), displayed first.
REQ-031 SHALL check underflow: s_tvalid dropped at pixel 10 -> underflow pulse once, black to frame end, display resumes on next frame's SOF.
REQ-032 SHALL check sof_err and reset: tuser=1 at pixel 20 -> sof_err pulse, beat shown at next (0,0); rst asserted mid-line -> all outputs at REQ-022 values within the same cycle.
